fir_xifu_ex: RTL and testbench

Execute stage of the FIR XIFU, directly downstream of the issue/decode stage.
- Consumes the registered ID/EX bundle and gates every instruction on its XIF commit/kill.
- Load/store (xfirlw/xfirsw): computes the address and drives the XIF memory request handshake.
- xfirdotp: computes a 2x16-bit signed dot-product-accumulate on the XIFU-internal register file.
- Every surviving instruction is forwarded to the writeback stage.

---
 rtl/fir_xifu_ex.sv | 234 +++++++++++++++++++++++
 tb/tb_fir_xifu_ex.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_xifu_ex.sv
// FIR XIFU execute stage: gates each instruction on its XIF commit/kill, issues xfirlw/xfirsw memory requests
// and computes xfirdotp. Optional FIR_XIFU_DOTP_SAT_EN: saturate xfirdotp to signed XLEN instead of wrapping.
module fir_xifu_ex #(
    parameter int ID_W = 4,
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            id2ex_valid_i,
    output logic            id2ex_ready_o,
    input  logic [1:0]      id2ex_instr_i,
    input  logic [ID_W-1:0] id2ex_id_i,
    input  logic [XLEN-1:0] id2ex_base_i,
    input  logic [11:0]     id2ex_offset_i,
    input  logic [4:0]      id2ex_rs1_i,
    input  logic [4:0]      id2ex_rs2_i,
    input  logic [4:0]      id2ex_rd_i,
    output logic [4:0]      rf_raddr_a_o,
    output logic [4:0]      rf_raddr_b_o,
    output logic [4:0]      rf_raddr_c_o,
    input  logic [XLEN-1:0] rf_rdata_a_i,
    input  logic [XLEN-1:0] rf_rdata_b_i,
    input  logic [XLEN-1:0] rf_rdata_c_i,
    input  logic            commit_valid_i,
    input  logic [ID_W-1:0] commit_id_i,
    input  logic            commit_kill_i,
    output logic            mem_valid_o,
    input  logic            mem_ready_i,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [ID_W-1:0] mem_id_o,
    output logic            ex2wb_valid_o,
    output logic            ex2wb_load_o,
    output logic            ex2wb_we_o,
    output logic [4:0]      ex2wb_rd_o,
    output logic [ID_W-1:0] ex2wb_id_o,
    output logic [XLEN-1:0] ex2wb_result_o
);
    localparam int NUM_ID = 2 ** ID_W;
    localparam logic [1:0] INSTR_INVALID = 2'b00;
    localparam logic [1:0] INSTR_LW      = 2'b01;
    localparam logic [1:0] INSTR_SW      = 2'b10;

`ifdef FIR_XIFU_DOTP_SAT_EN
    localparam int SUM_W = XLEN + 2;
`else
    localparam int SUM_W = XLEN;
`endif

    typedef enum logic [1:0] {IDLE, WAIT_COMMIT, MEM_REQ, EXEC} state_e;

    state_e            state_q, state_d;
    logic [1:0]        instr_q, instr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [XLEN-1:0]   base_q, base_d;
    logic [11:0]       offset_q, offset_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [NUM_ID-1:0] committed_q, committed_d, killed_q, killed_d;
    logic              ex2wb_valid_q, ex2wb_valid_d;
    logic              ex2wb_load_q, ex2wb_load_d;
    logic              ex2wb_we_q, ex2wb_we_d;
    logic [4:0]        ex2wb_rd_q, ex2wb_rd_d;
    logic [ID_W-1:0]   ex2wb_id_q, ex2wb_id_d;
    logic [XLEN-1:0]   ex2wb_result_q, ex2wb_result_d;

    logic              hit_kill, hit_commit, consume;
    logic [XLEN-1:0]   mem_addr;
    logic signed [31:0] prod_lo, prod_hi;
    logic [SUM_W-1:0]  dotp_sum;
    logic [XLEN-1:0]   dotp_result;

    // Same-cycle commit/kill for the held id counts as if it were already in the bitmap.
    assign hit_kill   = killed_q[id_q] | (commit_valid_i & commit_kill_i & (commit_id_i == id_q));
    assign hit_commit = committed_q[id_q] | (commit_valid_i & ~commit_kill_i & (commit_id_i == id_q));

    assign mem_addr = base_q + XLEN'($signed(offset_q));

    always_comb begin
        prod_lo  = 32'($signed(rf_rdata_a_i[15:0])) * 32'($signed(rf_rdata_b_i[15:0]));
        prod_hi  = 32'($signed(rf_rdata_a_i[31:16])) * 32'($signed(rf_rdata_b_i[31:16]));
        dotp_sum = SUM_W'($signed(rf_rdata_c_i)) + SUM_W'(prod_lo) + SUM_W'(prod_hi);
`ifdef FIR_XIFU_DOTP_SAT_EN
        // Representable in XLEN signed bits only if the top three sum bits agree.
        if (dotp_sum[SUM_W-1:XLEN-1] != 3'b000 && dotp_sum[SUM_W-1:XLEN-1] != 3'b111) begin
            dotp_result = dotp_sum[SUM_W-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
        end else begin
            dotp_result = dotp_sum[XLEN-1:0];
        end
`else
        dotp_result = dotp_sum;
`endif
    end

    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        id_d           = id_q;
        base_d         = base_q;
        offset_d       = offset_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        rd_d           = rd_q;
        consume        = 1'b0;
        ex2wb_valid_d  = 1'b0;
        ex2wb_load_d   = ex2wb_load_q;
        ex2wb_we_d     = ex2wb_we_q;
        ex2wb_rd_d     = ex2wb_rd_q;
        ex2wb_id_d     = ex2wb_id_q;
        ex2wb_result_d = ex2wb_result_q;

        unique case (state_q)
            IDLE: begin
                if (id2ex_valid_i) begin
                    instr_d  = id2ex_instr_i;
                    id_d     = id2ex_id_i;
                    base_d   = id2ex_base_i;
                    offset_d = id2ex_offset_i;
                    rs1_d    = id2ex_rs1_i;
                    rs2_d    = id2ex_rs2_i;
                    rd_d     = id2ex_rd_i;
                    state_d  = WAIT_COMMIT;
                end
            end
            WAIT_COMMIT: begin
                // INVALID never receives a commit, so it must leave the bitmaps alone.
                if (instr_q == INSTR_INVALID) begin
                    state_d = IDLE;
                end else if (hit_kill) begin
                    consume = 1'b1;
                    state_d = IDLE;
                end else if (hit_commit) begin
                    consume = 1'b1;
                    state_d = (instr_q == INSTR_LW || instr_q == INSTR_SW) ? MEM_REQ : EXEC;
                end
            end
            MEM_REQ: begin
                if (mem_ready_i) begin
                    ex2wb_valid_d  = 1'b1;
                    ex2wb_load_d   = (instr_q == INSTR_LW);
                    ex2wb_we_d     = (instr_q == INSTR_LW);
                    ex2wb_rd_d     = rd_q;
                    ex2wb_id_d     = id_q;
                    ex2wb_result_d = '0;
                    state_d        = IDLE;
                end
            end
            EXEC: begin
                ex2wb_valid_d  = 1'b1;
                ex2wb_load_d   = 1'b0;
                ex2wb_we_d     = 1'b1;
                ex2wb_rd_d     = rd_q;
                ex2wb_id_d     = id_q;
                ex2wb_result_d = dotp_result;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Set from the commit strobe first so a same-cycle commit for the held id is also consumed.
    always_comb begin
        committed_d = committed_q;
        killed_d    = killed_q;
        if (commit_valid_i) begin
            if (commit_kill_i) killed_d[commit_id_i] = 1'b1;
            else               committed_d[commit_id_i] = 1'b1;
        end
        if (consume) begin
            committed_d[id_q] = 1'b0;
            killed_d[id_q]    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            instr_q        <= '0;
            id_q           <= '0;
            base_q         <= '0;
            offset_q       <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            rd_q           <= '0;
            committed_q    <= '0;
            killed_q       <= '0;
            ex2wb_valid_q  <= 1'b0;
            ex2wb_load_q   <= 1'b0;
            ex2wb_we_q     <= 1'b0;
            ex2wb_rd_q     <= '0;
            ex2wb_id_q     <= '0;
            ex2wb_result_q <= '0;
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            id_q           <= id_d;
            base_q         <= base_d;
            offset_q       <= offset_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            rd_q           <= rd_d;
            committed_q    <= committed_d;
            killed_q       <= killed_d;
            ex2wb_valid_q  <= ex2wb_valid_d;
            ex2wb_load_q   <= ex2wb_load_d;
            ex2wb_we_q     <= ex2wb_we_d;
            ex2wb_rd_q     <= ex2wb_rd_d;
            ex2wb_id_q     <= ex2wb_id_d;
            ex2wb_result_q <= ex2wb_result_d;
        end
    end

    assign id2ex_ready_o = (state_q == IDLE);

    assign rf_raddr_a_o = rs1_q;
    assign rf_raddr_b_o = rs2_q;
    assign rf_raddr_c_o = rd_q;

    // Request fields are held registers, so they stay stable for the whole stall.
    assign mem_valid_o = (state_q == MEM_REQ);
    assign mem_addr_o  = mem_valid_o ? mem_addr : '0;
    assign mem_we_o    = mem_valid_o & (instr_q == INSTR_SW);
    assign mem_be_o    = 4'hF;
    assign mem_wdata_o = mem_valid_o ? rf_rdata_b_i : '0;
    assign mem_id_o    = mem_valid_o ? id_q : '0;

    assign ex2wb_valid_o  = ex2wb_valid_q;
    assign ex2wb_load_o   = ex2wb_load_q;
    assign ex2wb_we_o     = ex2wb_we_q;
    assign ex2wb_rd_o     = ex2wb_rd_q;
    assign ex2wb_id_o     = ex2wb_id_q;
    assign ex2wb_result_o = ex2wb_result_q;
endmodule

// File: tb/tb_fir_xifu_ex.sv
// Scoreboard bench for fir_xifu_ex: randomized and directed instructions against a plain-arithmetic model.
module tb_fir_xifu_ex;
  localparam logic [1:0] I_INV = 2'b00, I_LW = 2'b01, I_SW = 2'b10, I_DOTP = 2'b11;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic id2ex_valid_i = 0, id2ex_ready_o;
  logic [1:0] id2ex_instr_i = 0;
  logic [3:0] id2ex_id_i = 0;
  logic [31:0] id2ex_base_i = 0;
  logic [11:0] id2ex_offset_i = 0;
  logic [4:0] id2ex_rs1_i = 0, id2ex_rs2_i = 0, id2ex_rd_i = 0;
  logic [4:0] rf_raddr_a_o, rf_raddr_b_o, rf_raddr_c_o;
  logic [31:0] rf_rdata_a_i, rf_rdata_b_i, rf_rdata_c_i;
  logic commit_valid_i = 0, commit_kill_i = 0;
  logic [3:0] commit_id_i = 0;
  logic mem_valid_o, mem_ready_i = 0, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0] mem_be_o, mem_id_o;
  logic ex2wb_valid_o, ex2wb_load_o, ex2wb_we_o;
  logic [4:0] ex2wb_rd_o;
  logic [3:0] ex2wb_id_o;
  logic [31:0] ex2wb_result_o;

  logic [31:0] rf [32];
  assign rf_rdata_a_i = rf[rf_raddr_a_o];
  assign rf_rdata_b_i = rf[rf_raddr_b_o];
  assign rf_rdata_c_i = rf[rf_raddr_c_o];

  fir_xifu_ex dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id2ex_valid_i(id2ex_valid_i), .id2ex_ready_o(id2ex_ready_o), .id2ex_instr_i(id2ex_instr_i),
    .id2ex_id_i(id2ex_id_i), .id2ex_base_i(id2ex_base_i), .id2ex_offset_i(id2ex_offset_i),
    .id2ex_rs1_i(id2ex_rs1_i), .id2ex_rs2_i(id2ex_rs2_i), .id2ex_rd_i(id2ex_rd_i),
    .rf_raddr_a_o(rf_raddr_a_o), .rf_raddr_b_o(rf_raddr_b_o), .rf_raddr_c_o(rf_raddr_c_o),
    .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i), .rf_rdata_c_i(rf_rdata_c_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_id_o(mem_id_o),
    .ex2wb_valid_o(ex2wb_valid_o), .ex2wb_load_o(ex2wb_load_o), .ex2wb_we_o(ex2wb_we_o),
    .ex2wb_rd_o(ex2wb_rd_o), .ex2wb_id_o(ex2wb_id_o), .ex2wb_result_o(ex2wb_result_o)
  );

  typedef struct {
    logic ld; logic we; logic [4:0] rd; logic [3:0] id; logic [31:0] res; int ecyc;
  } wb_t;
  typedef struct {
    logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] id;
  } mem_t;

  wb_t  wbq[$];
  mem_t memq[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int stall_n = 0;
  bit hold_ready = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Dot product straight from the arithmetic definition, in 64-bit integers.
  function automatic logic [31:0] dotp_ref(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    longint s;
    s = longint'($signed(c)) + longint'($signed(a[15:0])) * longint'($signed(b[15:0]))
      + longint'($signed(a[31:16])) * longint'($signed(b[31:16]));
`ifdef FIR_XIFU_DOTP_SAT_EN
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
`endif
    return s[31:0];
  endfunction

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  // WB monitor
  initial begin
    wb_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && ex2wb_valid_o) begin
        if (wbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wb_unexpected: got pulse id=%0d rd=%0d res=%h, required none", ex2wb_id_o, ex2wb_rd_o, ex2wb_result_o);
        end else begin
          e = wbq.pop_front();
          check("wb_fields", {ex2wb_load_o, ex2wb_we_o, ex2wb_rd_o, ex2wb_id_o, ex2wb_result_o},
                {e.ld, e.we, e.rd, e.id, e.res});
          if (e.ecyc >= 0) check("wb_latency", cyc, e.ecyc);
        end
      end
    end
  end

  // Memory monitor and responder
  initial begin
    mem_t m;
    forever begin
      @(negedge clk_i);
      if (rst_ni && mem_valid_o) begin
        if (memq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL mem_unexpected: got addr=%h id=%0d, required no request", mem_addr_o, mem_id_o);
        end else begin
          m = memq[0];
          check("mem_req", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, mem_id_o},
                {m.addr, m.we, 4'hF, m.wdata, m.id});
        end
      end
      if (hold_ready || (stall_n > 0 && mem_valid_o)) mem_ready_i = 1'b0;
      else mem_ready_i = ($urandom_range(0, 2) != 0);
      if (stall_n > 0 && mem_valid_o) stall_n--;
      if (rst_ni && mem_valid_o && mem_ready_i && memq.size() > 0) void'(memq.pop_front());
    end
  end

  // Called right after a negedge; returns at the next negedge.
  task automatic do_commit(input logic [3:0] id, input logic kill, output int cc);
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
    @(posedge clk_i); #1; cc = cyc;
    @(negedge clk_i);
    commit_valid_i = 1'b0; commit_kill_i = 1'b0;
  endtask

  // mode 0: commit before accept, 1: commit dly cycles after, 2: kill dly cycles after
  task automatic issue(input logic [1:0] ins, input logic [3:0] id, input logic [31:0] base,
                       input logic [11:0] off, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input int mode, input int dly, input bit wait_done);
    int acc, cc, d, n;
    wb_t w;
    mem_t m;
    bit live;
    live = (ins != I_INV) && (mode != 2);
    @(negedge clk_i);
    if (ins != I_INV && mode == 0) do_commit(id, 1'b0, cc);
    id2ex_valid_i = 1'b1; id2ex_instr_i = ins; id2ex_id_i = id; id2ex_base_i = base;
    id2ex_offset_i = off; id2ex_rs1_i = r1; id2ex_rs2_i = r2; id2ex_rd_i = rd;
    n = 0;
    while (!id2ex_ready_o && n < 100) begin @(negedge clk_i); n++; end
    if (!id2ex_ready_o) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: ready=0, required 1");
      id2ex_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i); #1; acc = cyc;
    w.id = id; w.rd = rd; w.ld = (ins == I_LW); w.we = (ins == I_LW); w.res = 32'h0; w.ecyc = -1;
    if (live && ins != I_DOTP) begin
      m.addr = base + 32'($signed(off)); m.we = (ins == I_SW); m.wdata = rf[r2]; m.id = id;
      memq.push_back(m);
      wbq.push_back(w);
    end
    @(negedge clk_i);
    id2ex_valid_i = 1'b0;
    id2ex_instr_i = 2'($urandom);
    d = acc + 1;
    if (ins == I_INV) begin
      @(negedge clk_i);
      check("invalid_ready", id2ex_ready_o, 1'b1);
    end else if (mode != 0) begin
      repeat (dly) @(negedge clk_i);
      do_commit(id, mode == 2, cc);
      d = cc;
      if (mode == 2) check("kill_ready", id2ex_ready_o, 1'b1);
    end
    if (live && ins == I_DOTP) begin
      w.ld = 1'b0; w.we = 1'b1; w.res = dotp_ref(rf[r1], rf[r2], rf[rd]); w.ecyc = d + 1;
      wbq.push_back(w);
    end
    if (wait_done) begin
      n = 0;
      while ((wbq.size() != 0 || !id2ex_ready_o) && n < 300) begin @(negedge clk_i); n++; end
      if (n >= 300) begin
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: %0d wb pending, required 0", wbq.size());
        wbq.delete(); memq.delete();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ins;
    int mode, dly, n, cc;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    repeat (3) @(negedge clk_i);
    check("rst_mem", {mem_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_id_o,
                      rf_raddr_a_o, rf_raddr_b_o, rf_raddr_c_o}, '0);
    check("rst_wb", {ex2wb_valid_o, ex2wb_load_o, ex2wb_we_o, ex2wb_rd_o, ex2wb_id_o, ex2wb_result_o}, '0);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    check("ready_after_rst", id2ex_ready_o, 1'b1);

    // dot product, committed ahead of accept
    rf[1] = 32'h0002_0003; rf[2] = 32'h0004_0005; rf[3] = 32'd10;
    issue(I_DOTP, 4'd1, 32'h0, 12'h0, 5'd1, 5'd2, 5'd3, 0, 0, 1);
    // load with late commit and memory stall
    stall_n = 2;
    issue(I_LW, 4'd2, 32'h0000_1000, 12'hFFC, 5'd7, 5'd8, 5'd9, 1, 2, 1);
    // killed store, then the same id must wait for a fresh commit
    issue(I_SW, 4'd5, 32'h0000_2000, 12'h010, 5'd4, 5'd5, 5'd6, 2, 1, 1);
    issue(I_DOTP, 4'd5, 32'h0, 12'h0, 5'd1, 5'd2, 5'd3, 1, 2, 1);
    // address wraparound
    issue(I_SW, 4'd6, 32'hFFFF_FFFC, 12'h008, 5'd10, 5'd11, 5'd12, 1, 0, 1);
    // accumulation overflow
    rf[4] = 32'h7FFF_7FFF; rf[5] = 32'h7FFF_7FFF; rf[6] = 32'h7FFF_0000;
    issue(I_DOTP, 4'd7, 32'h0, 12'h0, 5'd4, 5'd5, 5'd6, 0, 0, 1);
    issue(I_INV, 4'd8, 32'h0, 12'h0, 5'd1, 5'd2, 5'd3, 1, 0, 1);

    for (int k = 0; k < 80; k++) begin
      ins = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 2);
      dly = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) stall_n = $urandom_range(1, 3);
      rf[$urandom_range(0, 31)] = $urandom;
      issue(ins, 4'($urandom), $urandom, 12'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            mode, dly, 1);
    end

    // reset in the middle of a stalled request, with a stale commit for id 9 pending
    @(negedge clk_i);
    do_commit(4'd9, 1'b0, cc);
    hold_ready = 1'b1;
    issue(I_LW, 4'd2, 32'h0000_3000, 12'h004, 5'd1, 5'd2, 5'd3, 0, 0, 0);
    n = 0;
    while (!mem_valid_o && n < 50) begin @(negedge clk_i); n++; end
    check("stall_reached", mem_valid_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_mem_valid", mem_valid_o, 1'b0);
    check("rst_mid_wb_valid", ex2wb_valid_o, 1'b0);
    wbq.delete(); memq.delete();
    hold_ready = 1'b0;
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    check("ready_after_mid_rst", id2ex_ready_o, 1'b1);
    issue(I_DOTP, 4'd9, 32'h0, 12'h0, 5'd4, 5'd5, 5'd6, 1, 3, 1);

    repeat (5) @(negedge clk_i);
    check("wbq_drained", wbq.size(), 0);
    check("memq_drained", memq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
